// File: rtl/rail_monitor_pkg.sv
// Shared types and constants for the rail supervisor: sample type, channel count,
// alarm debounce states and the channel-index width helper.
package rail_monitor_pkg;

    localparam int unsigned RAIL_DATA_W = 16;
    localparam int unsigned RAIL_NUMCH  = 5;

    typedef logic [RAIL_DATA_W-1:0] rail_sample_t;

    typedef enum logic [1:0] {
        ALM_IDLE,
        ALM_ARMING,
        ALM_ACTIVE,
        ALM_RECOVER
    } rail_alm_state_t;

    // A single channel still needs a one-bit index port.
    function automatic int unsigned chan_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rail_channel_avg.sv
// Per-channel block averager with a one-deep overwrite mailbox (hold/pend/ovr)
// and debounced over/under-voltage alarm state machines.
module rail_channel_avg
    import rail_monitor_pkg::*;
#(
    parameter int unsigned DATA_W   = RAIL_DATA_W,
    parameter int unsigned AVG_LOG2 = 4,
    parameter int unsigned DEB_CNT  = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] ov_thresh_i,
    input  logic [DATA_W-1:0] uv_thresh_i,
    input  logic              take_i,
    output logic [DATA_W-1:0] hold_o,
    output logic              pend_o,
    output logic              ovr_o,
    output logic              ov_alarm_o,
    output logic              uv_alarm_o,
    output logic              ov_rise_o,
    output logic              uv_rise_o
);

    localparam int unsigned CW = $clog2(DEB_CNT + 1);

    logic              evt;
    logic [DATA_W-1:0] avg;

    generate
        if (AVG_LOG2 == 0) begin : g_pass
            assign evt = valid_i;
            assign avg = data_i;
        end else begin : g_acc
            localparam int unsigned AW = DATA_W + AVG_LOG2;
            logic [AW-1:0]       acc_q, acc_d, sum;
            logic [AVG_LOG2-1:0] cnt_q, cnt_d;

            always_comb begin
                sum   = acc_q + AW'(data_i);
                acc_d = acc_q;
                cnt_d = cnt_q;
                if (valid_i) begin
                    cnt_d = cnt_q + AVG_LOG2'(1);
                    acc_d = (cnt_q == '1) ? '0 : sum;
                end
            end

            assign evt = valid_i && (cnt_q == '1);
            assign avg = DATA_W'(sum >> AVG_LOG2);

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    acc_q <= '0;
                    cnt_q <= '0;
                end else begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    logic [DATA_W-1:0] hold_q;
    logic              pend_q, ovr_q;

    // A new average landing in the cycle the old one is taken is not an overrun.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q <= '0;
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else if (evt) begin
            hold_q <= avg;
            pend_q <= 1'b1;
            if (pend_q && !take_i) begin
                ovr_q <= 1'b1;
            end else if (take_i) begin
                ovr_q <= 1'b0;
            end
        end else if (take_i) begin
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
        end
    end

    assign hold_o = hold_q;
    assign pend_o = pend_q;
    assign ovr_o  = ovr_q;

    logic [1:0] cond, alarm, rise;
    assign cond[0] = avg > ov_thresh_i;
    assign cond[1] = avg < uv_thresh_i;

    for (genvar k = 0; k < 2; k++) begin : g_alm
        rail_alm_state_t st_q;
        logic [CW-1:0]   deb_q, rec_q, deb_inc, rec_inc;
        logic            al_q;

        assign deb_inc = deb_q + CW'(1);
        assign rec_inc = rec_q + CW'(1);
        assign rise[k] = evt && cond[k] && (st_q == ALM_IDLE || st_q == ALM_ARMING)
                         && (deb_inc >= CW'(DEB_CNT));
        assign alarm[k] = al_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                st_q  <= ALM_IDLE;
                deb_q <= '0;
                rec_q <= '0;
                al_q  <= 1'b0;
            end else if (evt) begin
                unique case (st_q)
                    ALM_IDLE, ALM_ARMING: begin
                        if (cond[k]) begin
                            deb_q <= deb_inc;
                            if (deb_inc >= CW'(DEB_CNT)) begin
                                st_q  <= ALM_ACTIVE;
                                al_q  <= 1'b1;
                                rec_q <= '0;
                            end else begin
                                st_q <= ALM_ARMING;
                            end
                        end else begin
                            deb_q <= '0;
                            st_q  <= ALM_IDLE;
                        end
                    end
                    ALM_ACTIVE, ALM_RECOVER: begin
                        if (cond[k]) begin
                            rec_q <= '0;
                            st_q  <= ALM_ACTIVE;
                        end else begin
                            rec_q <= rec_inc;
                            if (rec_inc >= CW'(DEB_CNT)) begin
                                st_q  <= ALM_IDLE;
                                al_q  <= 1'b0;
                                deb_q <= '0;
                            end else begin
                                st_q <= ALM_RECOVER;
                            end
                        end
                    end
                    default: st_q <= ALM_IDLE;
                endcase
            end
        end
    end

    assign ov_alarm_o = alarm[0];
    assign uv_alarm_o = alarm[1];
    assign ov_rise_o  = rise[0];
    assign uv_rise_o  = rise[1];

endmodule

// File: rtl/rail_monitor.sv
// Multi-channel rail supervisor: per-channel averagers/alarms, round-robin output
// arbiter with a registered valid/ready port, and sticky fault bits.
module rail_monitor
    import rail_monitor_pkg::*;
#(
    parameter int unsigned NUMCH    = RAIL_NUMCH,
    parameter int unsigned DATA_W   = RAIL_DATA_W,
    parameter int unsigned AVG_LOG2 = 4,
    parameter int unsigned DEB_CNT  = 3
) (
    input  logic                         sclk,
    input  logic                         rst,
    input  logic [NUMCH-1:0][DATA_W-1:0] in_data,
    input  logic [NUMCH-1:0]             in_valid,
    input  logic [NUMCH-1:0][DATA_W-1:0] ov_thresh,
    input  logic [NUMCH-1:0][DATA_W-1:0] uv_thresh,
    input  logic [NUMCH-1:0]             fault_clr,
    output logic [DATA_W-1:0]            avg_data,
    output logic [chan_w(NUMCH)-1:0]     avg_chan,
    output logic                         avg_ovr,
    output logic                         avg_valid,
    input  logic                         avg_ready,
    output logic [NUMCH-1:0]             ov_alarm,
    output logic [NUMCH-1:0]             uv_alarm,
    output logic [NUMCH-1:0]             fault_sticky
);

    localparam int unsigned CHW = chan_w(NUMCH);

    logic [NUMCH-1:0][DATA_W-1:0] hold;
    logic [NUMCH-1:0]             pend, ovr, take, ov_rise, uv_rise;

    for (genvar i = 0; i < NUMCH; i++) begin : g_ch
        rail_channel_avg #(
            .DATA_W   (DATA_W),
            .AVG_LOG2 (AVG_LOG2),
            .DEB_CNT  (DEB_CNT)
        ) u_ch (
            .clk_i       (sclk),
            .rst_i       (rst),
            .data_i      (in_data[i]),
            .valid_i     (in_valid[i]),
            .ov_thresh_i (ov_thresh[i]),
            .uv_thresh_i (uv_thresh[i]),
            .take_i      (take[i]),
            .hold_o      (hold[i]),
            .pend_o      (pend[i]),
            .ovr_o       (ovr[i]),
            .ov_alarm_o  (ov_alarm[i]),
            .uv_alarm_o  (uv_alarm[i]),
            .ov_rise_o   (ov_rise[i]),
            .uv_rise_o   (uv_rise[i])
        );
    end

    logic [CHW-1:0]    last_q, win;
    logic              found;
    int unsigned       idx;
    logic [DATA_W-1:0] data_q;
    logic [CHW-1:0]    chan_q;
    logic              ovr_q, valid_q;
    logic [NUMCH-1:0]  sticky_q;

    always_comb begin
        win   = last_q;
        found = 1'b0;
        idx   = 0;
        take  = '0;
        for (int unsigned k = 1; k <= NUMCH; k++) begin
            idx = 32'(last_q) + k;
            if (idx >= NUMCH) begin
                idx = idx - NUMCH;
            end
            if (!found && pend[idx]) begin
                found = 1'b1;
                win   = CHW'(idx);
            end
        end
        if (avg_ready && found) begin
            take[win] = 1'b1;
        end
    end

    // The output slot only reloads while downstream is ready, so a stalled beat
    // stays put and averages completing meanwhile collapse in the channel mailbox.
    always_ff @(posedge sclk) begin
        if (rst) begin
            data_q   <= '0;
            chan_q   <= '0;
            ovr_q    <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= '0;
            sticky_q <= '0;
        end else begin
            sticky_q <= (sticky_q & ~fault_clr) | ov_rise | uv_rise;
            if (avg_ready) begin
                valid_q <= found;
                if (found) begin
                    data_q <= hold[win];
                    chan_q <= win;
                    ovr_q  <= ovr[win];
                    last_q <= win;
                end
            end
        end
    end

    assign avg_data     = data_q;
    assign avg_chan     = chan_q;
    assign avg_ovr      = ovr_q;
    assign avg_valid    = valid_q;
    assign fault_sticky = sticky_q;

endmodule
